// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode trap types: sequencer states, cause codes, vector-mode
// encoding and the trap target helper.
package machine_mode_types_1_12_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 4;

  typedef enum logic [1:0] {
    TRAP_IDLE,
    TRAP_DRAIN,
    TRAP_REDIRECT,
    TRAP_SLEEP
  } trap_state_t;

  localparam logic [CAUSE_W-1:0] EXC_MAL_INSN     = 4'd0;
  localparam logic [CAUSE_W-1:0] EXC_FAULT_INSN   = 4'd1;
  localparam logic [CAUSE_W-1:0] EXC_ILLEGAL_INSN = 4'd2;
  localparam logic [CAUSE_W-1:0] EXC_BREAKPOINT   = 4'd3;
  localparam logic [CAUSE_W-1:0] EXC_MAL_L        = 4'd4;
  localparam logic [CAUSE_W-1:0] EXC_FAULT_L      = 4'd5;
  localparam logic [CAUSE_W-1:0] EXC_MAL_S        = 4'd6;
  localparam logic [CAUSE_W-1:0] EXC_FAULT_S      = 4'd7;
  localparam logic [CAUSE_W-1:0] EXC_ENV          = 4'd11;

  localparam logic [CAUSE_W-1:0] INT_SOFT  = 4'd3;
  localparam logic [CAUSE_W-1:0] INT_TIMER = 4'd7;
  localparam logic [CAUSE_W-1:0] INT_EXT   = 4'd11;

  localparam logic [1:0] TRAP_VEC_MODE = 2'b01;

  typedef struct packed {
    logic               valid;
    logic               is_int;
    logic [CAUSE_W-1:0] code;
  } trap_cause_t;

  // Handler address: aligned base, offset by code*4 only for vectored interrupts.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input trap_cause_t     cause);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == TRAP_VEC_MODE && cause.is_int) begin
      return base + XLEN'({cause.code, 2'b00});
    end
    return base;
  endfunction

endpackage

// File: rtl/priv_cause_prio.sv
// Fixed-priority selection of one trap cause from exception flags and
// enabled interrupts; also flags any mask-enabled pending interrupt for wake.
module priv_cause_prio
  import machine_mode_types_1_12_pkg::*;
(
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env,
  input  logic        mal_l,
  input  logic        fault_l,
  input  logic        mal_s,
  input  logic        fault_s,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic        mie_global,
  input  logic [2:0]  mie_mask,
  output trap_cause_t cause_c,
  output logic        wake_c
);

  logic [2:0] int_pend;

  // mie_mask is {MEIE, MTIE, MSIE}
  assign int_pend = {ext_int, timer_int, soft_int} & mie_mask;
  assign wake_c   = |int_pend;

  always_comb begin
    cause_c = '0;
    if (fault_insn)        cause_c = {1'b1, 1'b0, EXC_FAULT_INSN};
    else if (mal_insn)     cause_c = {1'b1, 1'b0, EXC_MAL_INSN};
    else if (illegal_insn) cause_c = {1'b1, 1'b0, EXC_ILLEGAL_INSN};
    else if (breakpoint)   cause_c = {1'b1, 1'b0, EXC_BREAKPOINT};
    else if (env)          cause_c = {1'b1, 1'b0, EXC_ENV};
    else if (mal_l)        cause_c = {1'b1, 1'b0, EXC_MAL_L};
    else if (mal_s)        cause_c = {1'b1, 1'b0, EXC_MAL_S};
    else if (fault_l)      cause_c = {1'b1, 1'b0, EXC_FAULT_L};
    else if (fault_s)      cause_c = {1'b1, 1'b0, EXC_FAULT_S};
    else if (mie_global && int_pend[2]) cause_c = {1'b1, 1'b1, INT_EXT};
    else if (mie_global && int_pend[0]) cause_c = {1'b1, 1'b1, INT_SOFT};
    else if (mie_global && int_pend[1]) cause_c = {1'b1, 1'b1, INT_TIMER};
  end

endmodule

// File: rtl/priv_trap_sequencer.sv
// Machine-mode trap/return sequencer: selects an event, waits for the pipe to
// drain, then redirects fetch for one cycle with a matching CSR commit pulse.
module priv_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0200
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            fault_insn,
  input  logic            mal_insn,
  input  logic            illegal_insn,
  input  logic            breakpoint,
  input  logic            env,
  input  logic            mal_l,
  input  logic            fault_l,
  input  logic            mal_s,
  input  logic            fault_s,
  input  logic            ret,
  input  logic            wfi,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] badaddr,
  input  logic            pipe_clear,
  input  logic            ex_mem_stall,
  input  logic            timer_int,
  input  logic            soft_int,
  input  logic            ext_int,
  input  logic            mie_global,
  input  logic [2:0]      mie_mask,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_r,
  output logic            insert_pc,
  output logic [XLEN-1:0] priv_pc,
  output logic            intr,
  output logic            trap_commit,
  output logic            ret_commit,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mepc_w,
  output logic [XLEN-1:0] mtval_w,
  output logic            wfi_stall
);

  trap_state_t     state_q, state_n;
  trap_cause_t     cause_c;
  logic            wake_c;
  logic            take_trap_c, take_ret_c, redirect_n;
  logic            is_ret_q, is_ret_n;
  logic [XLEN-1:0] target_q, target_n;
  logic [XLEN-1:0] mcause_d, mepc_d, mtval_d;
  logic            insert_d, intr_d, trap_commit_d, ret_commit_d, wfi_stall_d;

  priv_cause_prio u_prio (
    .fault_insn  (fault_insn),
    .mal_insn    (mal_insn),
    .illegal_insn(illegal_insn),
    .breakpoint  (breakpoint),
    .env         (env),
    .mal_l       (mal_l),
    .fault_l     (fault_l),
    .mal_s       (mal_s),
    .fault_s     (fault_s),
    .timer_int   (timer_int),
    .soft_int    (soft_int),
    .ext_int     (ext_int),
    .mie_global  (mie_global),
    .mie_mask    (mie_mask),
    .cause_c     (cause_c),
    .wake_c      (wake_c)
  );

  assign take_trap_c = (state_q == TRAP_IDLE) && cause_c.valid;
  assign take_ret_c  = (state_q == TRAP_IDLE) && !cause_c.valid && ret;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= TRAP_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      TRAP_IDLE: begin
        if (cause_c.valid || ret) state_n = TRAP_DRAIN;
        else if (wfi)             state_n = TRAP_SLEEP;
      end
      TRAP_DRAIN:    if (pipe_clear && !ex_mem_stall) state_n = TRAP_REDIRECT;
      TRAP_REDIRECT: state_n = TRAP_IDLE;
      TRAP_SLEEP:    if (wake_c) state_n = TRAP_IDLE;
      default:       state_n = TRAP_IDLE;
    endcase
  end

  // Cause and target are frozen at selection; flags seen later are ignored.
  always_comb begin
    is_ret_n = is_ret_q;
    target_n = target_q;
    mcause_d = mcause;
    mepc_d   = mepc_w;
    mtval_d  = mtval_w;
    if (take_trap_c) begin
      is_ret_n                  = 1'b0;
      target_n                  = trap_target(mtvec, cause_c);
      mcause_d                  = '0;
      mcause_d[XLEN-1]          = cause_c.is_int;
      mcause_d[CAUSE_W-1:0]     = cause_c.code;
      mepc_d                    = epc;
      mtval_d                   = cause_c.is_int ? '0 : badaddr;
    end else if (take_ret_c) begin
      is_ret_n = 1'b1;
      target_n = mepc_r;
    end
    redirect_n    = (state_n == TRAP_REDIRECT);
    insert_d      = redirect_n;
    trap_commit_d = redirect_n && !is_ret_n;
    ret_commit_d  = redirect_n && is_ret_n;
    intr_d        = ((state_n == TRAP_DRAIN) || redirect_n) && !is_ret_n;
    wfi_stall_d   = (state_n == TRAP_SLEEP);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      is_ret_q    <= 1'b0;
      target_q    <= RESET_PC;
      mcause      <= '0;
      mepc_w      <= '0;
      mtval_w     <= '0;
      insert_pc   <= 1'b0;
      intr        <= 1'b0;
      trap_commit <= 1'b0;
      ret_commit  <= 1'b0;
      wfi_stall   <= 1'b0;
    end else begin
      is_ret_q    <= is_ret_n;
      target_q    <= target_n;
      mcause      <= mcause_d;
      mepc_w      <= mepc_d;
      mtval_w     <= mtval_d;
      insert_pc   <= insert_d;
      intr        <= intr_d;
      trap_commit <= trap_commit_d;
      ret_commit  <= ret_commit_d;
      wfi_stall   <= wfi_stall_d;
    end
  end

  assign priv_pc = insert_pc ? target_q : RESET_PC;

endmodule
